// File: rtl/mdeshuffle_unit.sv
// Matrix-store deshuffle unit: reads one beat per lane from the MRF, reorders the
// lane-interleaved elements back into sequential order and hands each beat to the
// sequential store buffer. Store instructions are queued in a small info FIFO.
module mdeshuffle_unit #(
    parameter int unsigned NR_EXITS      = 4,
    parameter int unsigned DLEN          = 64,
    parameter int unsigned INFO_DEP      = 4,
    parameter int unsigned SETS_PER_MREG = 8,
    parameter int unsigned SET_BITS      = 7,
    parameter int unsigned CNT_BITS      = 8,
    parameter int unsigned REQ_ID_BITS   = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    // store-instruction handshake
    input  logic                         meta_valid_i,
    output logic                         meta_ready_o,
    input  logic [REQ_ID_BITS-1:0]       meta_req_id_i,
    input  logic [1:0]                   meta_sew_i,
    input  logic [2:0]                   meta_md_i,
    input  logic [CNT_BITS-1:0]          meta_cmt_cnt_i,
    // per-lane MRF read request
    output logic [NR_EXITS-1:0]          rd_req_valid_o,
    input  logic [NR_EXITS-1:0]          rd_req_ready_i,
    output logic [SET_BITS-1:0]          rd_req_set_o,
    // per-lane read data
    input  logic [NR_EXITS-1:0]          rxs_valid_i,
    output logic [NR_EXITS-1:0]          rxs_ready_o,
    input  logic [NR_EXITS*DLEN-1:0]     rxs_data_i,
    // sequential store buffer
    output logic                         tx_seq_valid_o,
    input  logic                         tx_seq_ready_i,
    output logic [NR_EXITS*DLEN-1:0]     tx_seq_nb_o,
    // per-id completion pulse
    output logic [2**REQ_ID_BITS-1:0]    pe_resp_done_o
);

    localparam int unsigned IdxW  = $clog2(INFO_DEP);
    localparam int unsigned BeatW = NR_EXITS * DLEN;

    typedef enum logic [0:0] {StIssue, StGather} phase_e;

    // instruction-info queue; set and cnt of the head entry advance per beat
    logic [REQ_ID_BITS-1:0] q_id  [INFO_DEP];
    logic [1:0]             q_sew [INFO_DEP];
    logic [CNT_BITS-1:0]    q_cnt [INFO_DEP];
    logic [SET_BITS-1:0]    q_set [INFO_DEP];

    // pointers carry a wrap flag in the MSB
    logic [IdxW:0] wr_ptr_q, rd_ptr_q;
    logic [IdxW-1:0] wr_idx, rd_idx;
    logic empty, full, enq, deq;

    phase_e                 phase_q;
    logic [NR_EXITS-1:0]    acc_q, acc_d;
    logic [NR_EXITS-1:0]    slot_q, rxs_fire;
    logic [DLEN-1:0]        slot_data_q [NR_EXITS];
    logic                   tx_valid_q;
    logic [BeatW-1:0]       tx_nb_q;
    logic [2**REQ_ID_BITS-1:0] done_q;

    logic [REQ_ID_BITS-1:0] head_id;
    logic [1:0]             head_sew;
    logic [CNT_BITS-1:0]    head_cnt;
    logic [SET_BITS-1:0]    head_set;
    logic                   commit, last;
    logic [BeatW-1:0]       gath, desh;

    // queue status and head-entry view
    always_comb begin
        wr_idx   = wr_ptr_q[IdxW-1:0];
        rd_idx   = rd_ptr_q[IdxW-1:0];
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_idx == rd_idx) && (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
        head_id  = q_id[rd_idx];
        head_sew = q_sew[rd_idx];
        head_cnt = q_cnt[rd_idx];
        head_set = q_set[rd_idx];
    end

    // handshakes, beat completion and commit decision
    always_comb begin
        meta_ready_o   = !full;
        enq            = meta_valid_i && !full;
        rd_req_valid_o = (phase_q == StIssue && !empty) ? ~acc_q : '0;
        rd_req_set_o   = head_set;
        acc_d          = acc_q | (rd_req_valid_o & rd_req_ready_i);
        rxs_ready_o    = (phase_q == StGather) ? ~slot_q : '0;
        rxs_fire       = rxs_valid_i & rxs_ready_o;
        // data arriving this cycle completes the beat without waiting a cycle
        commit         = (phase_q == StGather) && (&(slot_q | rxs_fire)) &&
                         (!tx_valid_q || tx_seq_ready_i);
        last           = commit && (head_cnt == '0);
        deq            = last;
        tx_seq_valid_o = tx_valid_q;
        tx_seq_nb_o    = tx_nb_q;
        pe_resp_done_o = done_q;
    end

    // merge held slots with data arriving this cycle
    always_comb begin
        gath = '0;
        for (int l = 0; l < NR_EXITS; l++) begin
            gath[l*DLEN +: DLEN] = slot_q[l] ? slot_data_q[l] : rxs_data_i[l*DLEN +: DLEN];
        end
    end

    // element k of the beat comes from lane k mod NR_EXITS, element slot k div NR_EXITS
    always_comb begin
        desh = '0;
        unique case (head_sew)
            2'd0: for (int k = 0; k < BeatW / 8; k++)
                desh[k*8 +: 8] = gath[(k % NR_EXITS)*DLEN + (k / NR_EXITS)*8 +: 8];
            2'd1: for (int k = 0; k < BeatW / 16; k++)
                desh[k*16 +: 16] = gath[(k % NR_EXITS)*DLEN + (k / NR_EXITS)*16 +: 16];
            2'd2: for (int k = 0; k < BeatW / 32; k++)
                desh[k*32 +: 32] = gath[(k % NR_EXITS)*DLEN + (k / NR_EXITS)*32 +: 32];
            2'd3: for (int k = 0; k < BeatW / 64; k++)
                desh[k*64 +: 64] = gath[(k % NR_EXITS)*DLEN + (k / NR_EXITS)*64 +: 64];
            default: desh = '0;
        endcase
    end

    // queue pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // beat FSM with registered accept/slot/valid/done state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q    <= StIssue;
            acc_q      <= '0;
            slot_q     <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= '0;
        end else begin
            done_q <= '0;
            if (last) done_q[head_id] <= 1'b1;
            if (commit) begin
                acc_q      <= '0;
                slot_q     <= '0;
                phase_q    <= StIssue;
                tx_valid_q <= 1'b1;
            end else begin
                if (tx_seq_ready_i) tx_valid_q <= 1'b0;
                unique case (phase_q)
                    StIssue: begin
                        acc_q <= acc_d;
                        if (!empty && (&acc_d)) phase_q <= StGather;
                    end
                    StGather: slot_q <= slot_q | rxs_fire;
                    default: phase_q <= StIssue;
                endcase
            end
        end
    end

    // unreset payload: queue entries, gather slots, output beat
    always_ff @(posedge clk_i) begin
        if (enq) begin
            q_id[wr_idx]  <= meta_req_id_i;
            q_sew[wr_idx] <= meta_sew_i;
            q_cnt[wr_idx] <= meta_cmt_cnt_i;
            q_set[wr_idx] <= SET_BITS'(meta_md_i * SETS_PER_MREG);
        end
        if (commit) begin
            q_set[rd_idx] <= head_set + 1'b1;
            if (head_cnt != '0) q_cnt[rd_idx] <= head_cnt - 1'b1;
            tx_nb_q <= desh;
        end
        for (int l = 0; l < NR_EXITS; l++) begin
            if (rxs_fire[l]) slot_data_q[l] <= rxs_data_i[l*DLEN +: DLEN];
        end
    end

    // protocol checks on the lane interfaces
    a_rxs_in_gather: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|rxs_valid_i) |-> (phase_q == StGather));
    a_set_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (|(rd_req_valid_o & ~rd_req_ready_i)) |=> $stable(rd_req_set_o));

endmodule

// File: tb/tb_mdeshuffle_unit.sv
// Bench for mdeshuffle_unit: lane responder model, output/done scoreboards,
// a vector table for single-beat stores and hand sequences for multi-cycle cases.
module tb_mdeshuffle_unit;

    localparam int NR = 4;
    localparam int DL = 64;
    localparam int RIB = 3;
    localparam int SB = 7;
    localparam int CB = 8;
    localparam int BW = NR * DL;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              meta_valid_i, meta_ready_o;
    logic [RIB-1:0]    meta_req_id_i;
    logic [1:0]        meta_sew_i;
    logic [2:0]        meta_md_i;
    logic [CB-1:0]     meta_cmt_cnt_i;
    logic [NR-1:0]     rd_req_valid_o, rd_req_ready_i;
    logic [SB-1:0]     rd_req_set_o;
    logic [NR-1:0]     rxs_valid_i, rxs_ready_o;
    logic [BW-1:0]     rxs_data_i;
    logic              tx_seq_valid_o, tx_seq_ready_i;
    logic [BW-1:0]     tx_seq_nb_o;
    logic [2**RIB-1:0] pe_resp_done_o;

    mdeshuffle_unit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .meta_valid_i   (meta_valid_i),
        .meta_ready_o   (meta_ready_o),
        .meta_req_id_i  (meta_req_id_i),
        .meta_sew_i     (meta_sew_i),
        .meta_md_i      (meta_md_i),
        .meta_cmt_cnt_i (meta_cmt_cnt_i),
        .rd_req_valid_o (rd_req_valid_o),
        .rd_req_ready_i (rd_req_ready_i),
        .rd_req_set_o   (rd_req_set_o),
        .rxs_valid_i    (rxs_valid_i),
        .rxs_ready_o    (rxs_ready_o),
        .rxs_data_i     (rxs_data_i),
        .tx_seq_valid_o (tx_seq_valid_o),
        .tx_seq_ready_i (tx_seq_ready_i),
        .tx_seq_nb_o    (tx_seq_nb_o),
        .pe_resp_done_o (pe_resp_done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_run = 0;
    int n_fail = 0;

    logic [BW-1:0] exp_q[$];
    int            done_q[$];
    int            set_log[$];
    logic [BW-1:0] last_nb;

    int            rd_dly[NR];
    int            rsp_dly[NR];
    int            wait_cnt[NR];
    int            rsp_cnt[NR];
    bit            pend[NR];
    logic [SB-1:0] pend_set[NR];

    typedef struct {
        int          id;
        int          sew;
        int          md;
        int          exp_set;
        logic [63:0] exp_lo;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // MRF contents: lane l, set s, byte i holds (l*8 + i + s - 16) mod 256
    function automatic logic [DL-1:0] lane_word(input int l, input int s);
        logic [DL-1:0] w;
        for (int i = 0; i < DL / 8; i++) w[i*8 +: 8] = 8'(l * 8 + i + s - 16);
        return w;
    endfunction

    // reference beat, nibble by nibble: out nibble k*EN+j = lane k%NR nibble (k/NR)*EN+j
    function automatic logic [BW-1:0] model_beat(input int sew, input int s);
        logic [BW-1:0] g, o;
        int en;
        en = 2 << sew;
        o = '0;
        for (int l = 0; l < NR; l++) g[l*DL +: DL] = lane_word(l, s);
        for (int k = 0; k < BW / (4 * en); k++)
            for (int j = 0; j < en; j++)
                o[(k*en + j)*4 +: 4] = g[(k % NR)*DL + ((k / NR)*en + j)*4 +: 4];
        return o;
    endfunction

    // lane responder: delayed read accept, delayed data return, only while DUT is ready
    initial begin : responder
        rd_req_ready_i = '0;
        rxs_valid_i = '0;
        rxs_data_i = '0;
        forever begin
            @(negedge clk_i);
            #1;
            for (int l = 0; l < NR; l++) begin
                if (!rst_ni) begin
                    pend[l] = 1'b0;
                    wait_cnt[l] = 0;
                    rsp_cnt[l] = 0;
                    rd_req_ready_i[l] = 1'b0;
                    rxs_valid_i[l] = 1'b0;
                    continue;
                end
                rd_req_ready_i[l] = rd_req_valid_o[l] && (wait_cnt[l] >= rd_dly[l]);
                if (rd_req_valid_o[l] && !rd_req_ready_i[l]) wait_cnt[l]++;
                if (rd_req_valid_o[l] && rd_req_ready_i[l]) begin
                    chk("rd_reissue", pend[l], 0);
                    pend[l] = 1'b1;
                    pend_set[l] = rd_req_set_o;
                    wait_cnt[l] = 0;
                    rsp_cnt[l] = 0;
                    if (l == 0) set_log.push_back(int'(rd_req_set_o));
                end
                rxs_valid_i[l] = pend[l] && rxs_ready_o[l] && (rsp_cnt[l] >= rsp_dly[l]);
                if (rxs_valid_i[l]) begin
                    rxs_data_i[l*DL +: DL] = lane_word(l, int'(pend_set[l]));
                    pend[l] = 1'b0;
                end else if (pend[l] && rxs_ready_o[l]) begin
                    rsp_cnt[l]++;
                end
            end
        end
    end

    // output and completion scoreboards
    initial begin : out_mon
        int id;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_ni && tx_seq_valid_o && tx_seq_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got beat %0h, required none", tx_seq_nb_o);
                end else begin
                    last_nb = tx_seq_nb_o;
                    chk("tx_beat", tx_seq_nb_o, exp_q.pop_front());
                end
            end
            if (pe_resp_done_o != '0) begin
                if (done_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL done_unexpected: got %b, required none", pe_resp_done_o);
                end else begin
                    id = done_q.pop_front();
                    chk("done_id", pe_resp_done_o, 8'(1) << id);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic push_exp(input int id, input int sew, input int md, input int cnt);
        for (int b = 0; b <= cnt; b++) exp_q.push_back(model_beat(sew, (md * 8 + b) % 128));
        done_q.push_back(id);
    endtask

    // called at a negedge; returns at a negedge with meta_valid_i low
    task automatic send(input int id, input int sew, input int md, input int cnt);
        int t;
        meta_valid_i = 1'b1;
        meta_req_id_i = 3'(id);
        meta_sew_i = 2'(sew);
        meta_md_i = 3'(md);
        meta_cmt_cnt_i = 8'(cnt);
        t = 0;
        while (!meta_ready_o && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (!meta_ready_o) chk("send_timeout", meta_ready_o, 1);
        else push_exp(id, sew, md, cnt);
        @(negedge clk_i);
        meta_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && t < max) begin
            @(negedge clk_i);
            t++;
        end
        repeat (2) @(negedge clk_i);
        chk({name, "_drain"}, exp_q.size() + done_q.size(), 0);
    endtask

    initial begin : main
        int t;
        vecs[0] = '{id: 1, sew: 0, md: 2, exp_set: 16, exp_lo: 64'h1911_0901_1810_0800};
        vecs[1] = '{id: 2, sew: 1, md: 2, exp_set: 16, exp_lo: 64'h1918_1110_0908_0100};
        vecs[2] = '{id: 3, sew: 2, md: 2, exp_set: 16, exp_lo: 64'h0B0A_0908_0302_0100};
        vecs[3] = '{id: 4, sew: 3, md: 3, exp_set: 24, exp_lo: 64'h0F0E_0D0C_0B0A_0908};
        vecs[4] = '{id: 5, sew: 0, md: 0, exp_set: 0,  exp_lo: 64'h0901_F9F1_0800_F8F0};

        meta_valid_i = 1'b0;
        meta_req_id_i = '0;
        meta_sew_i = '0;
        meta_md_i = '0;
        meta_cmt_cnt_i = '0;
        tx_seq_ready_i = 1'b1;
        for (int l = 0; l < NR; l++) begin
            rd_dly[l] = 0;
            rsp_dly[l] = 0;
        end

        // reset state
        repeat (3) @(negedge clk_i);
        chk("rst_rd_valid", rd_req_valid_o, 0);
        chk("rst_rxs_ready", rxs_ready_o, 0);
        chk("rst_tx_valid", tx_seq_valid_o, 0);
        chk("rst_done", pe_resp_done_o, 0);
        chk("rst_meta_ready", meta_ready_o, 1);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // single-beat table across all element widths
        for (int v = 0; v < 5; v++) begin
            set_log.delete();
            send(vecs[v].id, vecs[v].sew, vecs[v].md, 0);
            wait_drain("tbl", 50);
            chk("tbl_nreq", set_log.size(), 1);
            if (set_log.size() > 0) chk("tbl_set", set_log[0], vecs[v].exp_set);
            chk("tbl_lo", last_nb[63:0], vecs[v].exp_lo);
        end

        // first request the cycle after enqueue, tx valid two cycles after read accept
        meta_valid_i = 1'b1;
        meta_req_id_i = 3'd6;
        meta_sew_i = 2'd0;
        meta_md_i = 3'd2;
        meta_cmt_cnt_i = 8'd0;
        push_exp(6, 0, 2, 0);
        @(negedge clk_i);
        meta_valid_i = 1'b0;
        chk("first_req", rd_req_valid_o, 4'hF);
        t = 0;
        while (!tx_seq_valid_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("latency", t, 2);
        wait_drain("lat", 50);

        // multi-beat 64-bit store: sets 24..27, one done after the fourth beat
        set_log.delete();
        send(7, 3, 3, 3);
        wait_drain("multi", 100);
        chk("multi_nreq", set_log.size(), 4);
        for (int i = 0; i < 4 && i < set_log.size(); i++) chk("multi_set", set_log[i], 24 + i);

        // skewed lane accepts and out-of-order responses
        rd_dly = '{0, 2, 1, 4};
        rsp_dly = '{3, 0, 2, 1};
        send(0, 0, 2, 0);
        wait_drain("skew", 100);
        chk("skew_lo", last_nb[63:0], 64'h1911_0901_1810_0800);
        rd_dly = '{0, 0, 0, 0};
        rsp_dly = '{0, 0, 0, 0};

        // back-pressure: queue fills, stalled beat issues no new reads, then drains in order
        tx_seq_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(i, 0, i, 0);
        repeat (6) @(negedge clk_i);
        chk("full_ready", meta_ready_o, 0);
        chk("stall_txv", tx_seq_valid_o, 1);
        chk("stall_noreq", rd_req_valid_o, 0);
        chk("stall_pending", done_q.size(), 4);
        tx_seq_ready_i = 1'b1;
        wait_drain("bp", 200);

        // reset while gathering: everything dropped, no done, then a clean instruction
        rsp_dly = '{10, 10, 10, 10};
        send(5, 0, 2, 0);
        t = 0;
        while (rxs_ready_o == '0 && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("gather_reached", rxs_ready_o, 4'hF);
        rst_ni = 1'b0;
        exp_q.delete();
        done_q.delete();
        @(posedge clk_i);
        #1;
        chk("mrst_rd_valid", rd_req_valid_o, 0);
        chk("mrst_rxs_ready", rxs_ready_o, 0);
        chk("mrst_tx_valid", tx_seq_valid_o, 0);
        chk("mrst_done", pe_resp_done_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        rsp_dly = '{0, 0, 0, 0};
        repeat (5) @(negedge clk_i);
        send(6, 1, 2, 0);
        wait_drain("post_rst", 50);
        chk("post_rst_lo", last_nb[63:0], 64'h1918_1110_0908_0100);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
